// File: rtl/uart_txrx.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
//  Module   : uart_txrx
//  Purpose  : Full-duplex 8N1 UART. One transmitter and one receiver share a
//             free-running baud generator with 16x oversampling.
//  Ports    : clk       - system clock, rising edge
//             areset    - synchronous, active-high reset
//             divisor   - clocks per baud tick (0 behaves as 1)
//             start     - transmit request level (held high = streaming)
//             in_data   - byte to send, captured at frame start
//             tx        - serial output, idle high
//             tx_done   - one-clock pulse during the last clock of a stop bit
//             rx        - asynchronous serial input
//             out_data  - last correctly framed received byte
//             rx_done   - one-clock pulse when out_data is updated
//  Revision : 1.0 - initial release
// ============================================================================
module uart_txrx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 tx,
  output logic                 tx_done,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 rx_done
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_PENULT = OS_W'(OVERSAMPLE - 2);
  localparam logic [OS_W-1:0]  OS_MID    = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------- baud generator ----------------
  logic [DIV_WIDTH-1:0] baud_cnt;
  logic [DIV_WIDTH-1:0] baud_div;
  logic [DIV_WIDTH-1:0] div_eff;
  logic                 tick_pre;
  logic                 tick;

  assign div_eff  = (divisor == '0) ? DIV_WIDTH'(1) : divisor;
  // tick_pre is the raw wrap condition; the FSMs act on its registered copy,
  // so tick_pre announces the next FSM tick one clock ahead.
  assign tick_pre = (baud_cnt == baud_div - DIV_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (areset) begin
      baud_cnt <= '0;
      baud_div <= div_eff;
      tick     <= 1'b0;
    end else begin
      tick <= tick_pre;
      if (tick_pre) begin
        baud_cnt <= '0;
        baud_div <= div_eff;   // divisor changes only land on a wrap
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  // ---------------- transmitter ----------------
  state_t               tx_state;
  logic [OS_W-1:0]      tx_tcnt;
  logic [BIT_W-1:0]     tx_bcnt;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_last_clk;

  // True when the coming edge is the final tick of the stop bit, so tx_done
  // covers the last stop-bit clock and a producer reacting to it still gets
  // its new in_data latched for a back-to-back frame.
  assign tx_last_clk = (tx_state == S_STOP) && tick_pre &&
                       ((tick && tx_tcnt == OS_PENULT) || (!tick && tx_tcnt == OS_LAST));

  always_ff @(posedge clk) begin
    if (areset) begin
      tx_state <= S_IDLE;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_shreg <= '0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= tx_last_clk;
      case (tx_state)
        S_IDLE: begin
          tx <= 1'b1;
          if (tick && start) begin
            tx_shreg <= in_data;
            tx_tcnt  <= '0;
            tx       <= 1'b0;
            tx_state <= S_START;
          end
        end
        S_START: if (tick) begin
          if (tx_tcnt == OS_LAST) begin
            tx_tcnt  <= '0;
            tx_bcnt  <= '0;
            tx       <= tx_shreg[0];
            tx_state <= S_DATA;
          end else tx_tcnt <= tx_tcnt + 1'b1;
        end
        S_DATA: if (tick) begin
          if (tx_tcnt == OS_LAST) begin
            tx_tcnt <= '0;
            if (tx_bcnt == BIT_LAST) begin
              tx       <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_bcnt  <= tx_bcnt + 1'b1;
              tx_shreg <= tx_shreg >> 1;
              tx       <= tx_shreg[1];
            end
          end else tx_tcnt <= tx_tcnt + 1'b1;
        end
        S_STOP: if (tick) begin
          if (tx_tcnt == OS_LAST) begin
            tx_tcnt <= '0;
            if (start) begin
              tx_shreg <= in_data;
              tx       <= 1'b0;
              tx_state <= S_START;
            end else begin
              tx       <= 1'b1;
              tx_state <= S_IDLE;
            end
          end else tx_tcnt <= tx_tcnt + 1'b1;
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic [1:0] rx_sync;
  logic       rx_s;
  logic       rx_prev;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk) begin
    if (areset) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      rx_prev <= rx_s;
    end
  end

  state_t               rx_state;
  logic [OS_W-1:0]      rx_tcnt;
  logic [BIT_W-1:0]     rx_bcnt;
  logic [DATA_BITS-1:0] rx_shreg;

  always_ff @(posedge clk) begin
    if (areset) begin
      rx_state <= S_IDLE;
      rx_tcnt  <= '0;
      rx_bcnt  <= '0;
      rx_shreg <= '0;
      out_data <= '0;
      rx_done  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (rx_state)
        // Arm on a high-to-low transition so a line still low after a
        // framing error does not start a phantom frame.
        S_IDLE: if (rx_prev && !rx_s) begin
          rx_tcnt  <= '0;
          rx_state <= S_START;
        end
        S_START: if (tick) begin
          if (rx_tcnt == OS_MID) begin
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
            rx_state <= rx_s ? S_IDLE : S_DATA;
          end else rx_tcnt <= rx_tcnt + 1'b1;
        end
        S_DATA: if (tick) begin
          if (rx_tcnt == OS_LAST) begin
            rx_tcnt  <= '0;
            rx_shreg <= {rx_s, rx_shreg[DATA_BITS-1:1]};
            if (rx_bcnt == BIT_LAST) rx_state <= S_STOP;
            else                     rx_bcnt  <= rx_bcnt + 1'b1;
          end else rx_tcnt <= rx_tcnt + 1'b1;
        end
        S_STOP: if (tick) begin
          if (rx_tcnt == OS_LAST) begin
            rx_tcnt <= '0;
            if (rx_s) begin
              out_data <= rx_shreg;
              rx_done  <= 1'b1;
            end
            rx_state <= S_IDLE;
          end else rx_tcnt <= rx_tcnt + 1'b1;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_txrx.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
//  Module   : tb_uart_txrx
//  Purpose  : Self-checking bench for uart_txrx. Instance A loops back to
//             itself or is driven by the bench; instance B, on a slower,
//             slightly detuned clock, receives A's stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_txrx;

  logic        clk_a = 1'b0, clk_b = 1'b0;
  logic        rst_a, rst_b;
  logic [15:0] div_a, div_b;
  logic        start_a, start_b;
  logic [7:0]  in_a, in_b;
  logic        tx_a, tx_b, tx_done_a, tx_done_b;
  logic        rx_a, rx_b;
  logic [7:0]  out_a, out_b;
  logic        rx_done_a, rx_done_b;
  logic [1:0]  rx_sel;   // 0: loopback, 1: bench-driven, 2: from B
  logic        drv_rx;
  logic        b_en;

  always #5    clk_a = ~clk_a;
  always #10.1 clk_b = ~clk_b;   // ~1% slower than A's bit rate at div 20/10

  assign rx_a = (rx_sel == 2'd0) ? tx_a : (rx_sel == 2'd1) ? drv_rx : tx_b;
  assign rx_b = b_en ? tx_a : 1'b1;

  uart_txrx #(.DATA_BITS(8), .OVERSAMPLE(16), .DIV_WIDTH(16)) dut_a (
    .clk(clk_a), .areset(rst_a), .divisor(div_a), .start(start_a),
    .in_data(in_a), .tx(tx_a), .tx_done(tx_done_a), .rx(rx_a),
    .out_data(out_a), .rx_done(rx_done_a));

  uart_txrx #(.DATA_BITS(8), .OVERSAMPLE(16), .DIV_WIDTH(16)) dut_b (
    .clk(clk_b), .areset(rst_b), .divisor(div_b), .start(start_b),
    .in_data(in_b), .tx(tx_b), .tx_done(tx_done_b), .rx(rx_b),
    .out_data(out_b), .rx_done(rx_done_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboards and pulse monitors ----------------
  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  int rx_cnt_a = 0, rx_cnt_b = 0, txd_cnt_a = 0, width_viol = 0;
  logic txd_prev_a = 1'b0, rxd_prev_a = 1'b0, rxd_prev_b = 1'b0;

  always @(negedge clk_a) begin
    if (rx_done_a) begin
      rx_cnt_a++;
      if (exp_q_a.size() == 0) check("rx_a_unexpected", {24'd0, out_a}, 32'hFFFF_FFFF);
      else                     check("rx_a_byte", {24'd0, out_a}, {24'd0, exp_q_a.pop_front()});
    end
    if (tx_done_a) txd_cnt_a++;
    if ((tx_done_a && txd_prev_a) || (rx_done_a && rxd_prev_a)) width_viol++;
    txd_prev_a = tx_done_a;
    rxd_prev_a = rx_done_a;
  end

  always @(negedge clk_b) begin
    if (rx_done_b) begin
      rx_cnt_b++;
      if (exp_q_b.size() == 0) check("rx_b_unexpected", {24'd0, out_b}, 32'hFFFF_FFFF);
      else                     check("rx_b_byte", {24'd0, out_b}, {24'd0, exp_q_b.pop_front()});
    end
    if (rx_done_b && rxd_prev_b) width_viol++;
    rxd_prev_b = rx_done_b;
  end

  // ---------------- helpers ----------------
  task automatic wait_tx_low(input string name);
    int n = 0;
    while (tx_a !== 1'b0 && n < 20000) begin @(negedge clk_a); n++; end
    check(name, {31'd0, tx_a}, 32'd0);
  endtask

  task automatic wait_tx_done(input string name);
    int n = 0;
    while (tx_done_a !== 1'b1 && n < 20000) begin @(negedge clk_a); n++; end
    check(name, {31'd0, tx_done_a}, 32'd1);
  endtask

  task automatic send_loop(input logic [7:0] d);
    @(negedge clk_a);
    in_a = d; start_a = 1'b1;
    wait_tx_low("loop_start_bit");
    start_a = 1'b0;
    wait_tx_done("loop_tx_done");
    @(negedge clk_a);
  endtask

  // Bench-driven frame at 64 clocks per bit (divisor 4).
  task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
    drv_rx = 1'b0;
    repeat (64) @(negedge clk_a);
    for (int k = 0; k < 8; k++) begin
      drv_rx = d[k];
      repeat (64) @(negedge clk_a);
    end
    drv_rx = stop_bit;
    repeat (64) @(negedge clk_a);
    drv_rx = 1'b1;
    repeat (64) @(negedge clk_a);
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] dexp;
  } vec_t;

  initial begin
    vec_t vecs[6];
    logic [7:0] a5;
    logic [7:0] stream[10];
    int n, viol, base_rx, base_txd;

    vecs[0] = '{8'h00, 8'h00};
    vecs[1] = '{8'hFF, 8'hFF};
    vecs[2] = '{8'h3C, 8'h3C};
    vecs[3] = '{8'h81, 8'h81};
    vecs[4] = '{8'h5A, 8'h5A};
    vecs[5] = '{8'h01, 8'h01};
    a5 = 8'hA5;

    rst_a = 1'b1; rst_b = 1'b1; div_a = 16'd4; div_b = 16'd10;
    start_a = 1'b0; start_b = 1'b0; in_a = 8'h00; in_b = 8'h00;
    rx_sel = 2'd0; drv_rx = 1'b1; b_en = 1'b0;
    repeat (10) @(negedge clk_a);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk_a);

    // reset state
    check("rst_tx", {31'd0, tx_a}, 32'd1);
    check("rst_tx_done", {31'd0, tx_done_a}, 32'd0);
    check("rst_rx_done", {31'd0, rx_done_a}, 32'd0);
    check("rst_out_data", {24'd0, out_a}, 32'd0);
    check("rst_out_data_b", {24'd0, out_b}, 32'd0);

    // idle for 500 clocks
    viol = 0;
    repeat (500) begin
      @(negedge clk_a);
      if (tx_a !== 1'b1 || tx_done_a !== 1'b0 || rx_done_a !== 1'b0) viol++;
    end
    check("idle_violations", viol, 0);
    check("idle_out_data", {24'd0, out_a}, 32'd0);

    // 0xA5 waveform and loopback
    base_txd = txd_cnt_a;
    exp_q_a.push_back(8'hA5);
    in_a = 8'hA5; start_a = 1'b1;
    wait_tx_low("a5_start_edge");
    start_a = 1'b0;
    n = 0;
    while (tx_a === 1'b0 && n < 1000) begin n++; @(negedge clk_a); end
    check("a5_start_len", n, 64);
    for (int k = 0; k < 8; k++) begin
      repeat (32) @(negedge clk_a);
      check($sformatf("a5_bit%0d", k), {31'd0, tx_a}, {31'd0, a5[k]});
      repeat (32) @(negedge clk_a);
    end
    repeat (32) @(negedge clk_a);
    check("a5_stop", {31'd0, tx_a}, 32'd1);
    wait_tx_done("a5_tx_done");
    repeat (20) @(negedge clk_a);
    check("a5_tx_done_count", txd_cnt_a - base_txd, 1);
    check("a5_out_data", {24'd0, out_a}, 32'hA5);
    check("a5_tx_idle", {31'd0, tx_a}, 32'd1);

    // table-driven loopback frames
    for (int i = 0; i < 6; i++) begin
      exp_q_a.push_back(vecs[i].dexp);
      send_loop(vecs[i].din);
    end
    repeat (20) @(negedge clk_a);
    check("table_queue_empty", exp_q_a.size(), 0);
    check("table_last_out", {24'd0, out_a}, {24'd0, vecs[5].dexp});

    // back-to-back 0x00 then 0xFF; 0xFF is presented after the first latch
    exp_q_a.push_back(8'h00);
    exp_q_a.push_back(8'hFF);
    @(negedge clk_a);
    in_a = 8'h00; start_a = 1'b1;
    wait_tx_low("b2b_first_start");
    in_a = 8'hFF;
    wait_tx_done("b2b_first_done");
    check("b2b_stop_during_done", {31'd0, tx_a}, 32'd1);
    @(negedge clk_a);
    check("b2b_next_start", {31'd0, tx_a}, 32'd0);
    start_a = 1'b0;
    wait_tx_done("b2b_second_done");
    repeat (20) @(negedge clk_a);
    check("b2b_queue_empty", exp_q_a.size(), 0);
    check("b2b_tx_idle", {31'd0, tx_a}, 32'd1);

    // false start then a good 0x3C, bench drives rx
    rx_sel = 2'd1;
    repeat (20) @(negedge clk_a);
    base_rx = rx_cnt_a;
    drv_rx = 1'b0;
    repeat (12) @(negedge clk_a);   // 3 ticks at divisor 4
    drv_rx = 1'b1;
    repeat (200) @(negedge clk_a);
    check("false_start_no_rx", rx_cnt_a - base_rx, 0);
    exp_q_a.push_back(8'h3C);
    drive_frame(8'h3C, 1'b1);
    check("after_false_rx_count", rx_cnt_a - base_rx, 1);
    check("after_false_out", {24'd0, out_a}, 32'h3C);

    // framing error: 0x55 with stop bit low
    base_rx = rx_cnt_a;
    drive_frame(8'h55, 1'b0);
    repeat (200) @(negedge clk_a);
    check("framing_no_rx", rx_cnt_a - base_rx, 0);
    check("framing_out_kept", {24'd0, out_a}, 32'h3C);

    // A streams 10 random bytes to B (divisors scaled from 651/326)
    rx_sel = 2'd2; b_en = 1'b1; div_a = 16'd20;
    repeat (100) @(negedge clk_a);
    base_rx = rx_cnt_b;
    for (int i = 0; i < 10; i++) stream[i] = 8'($urandom_range(0, 255));
    in_a = stream[0]; exp_q_b.push_back(stream[0]);
    start_a = 1'b1;
    for (int i = 1; i < 10; i++) begin
      wait_tx_done($sformatf("stream_done%0d", i));
      in_a = stream[i];
      exp_q_b.push_back(stream[i]);
      @(negedge clk_a);
    end
    start_a = 1'b0;
    wait_tx_done("stream_done_last");
    repeat (400) @(negedge clk_a);
    check("stream_rx_count", rx_cnt_b - base_rx, 10);
    check("stream_queue_empty", exp_q_b.size(), 0);

    // reset during DATA
    b_en = 1'b0; rx_sel = 2'd0; div_a = 16'd4;
    repeat (200) @(negedge clk_a);
    in_a = 8'hC3; start_a = 1'b1;
    wait_tx_low("mid_rst_start");
    start_a = 1'b0;
    repeat (64 * 3) @(negedge clk_a);
    base_txd = txd_cnt_a;
    base_rx = rx_cnt_a;
    rst_a = 1'b1;
    @(negedge clk_a);
    check("mid_rst_tx", {31'd0, tx_a}, 32'd1);
    check("mid_rst_tx_done", {31'd0, tx_done_a}, 32'd0);
    rst_a = 1'b0;
    viol = 0;
    repeat (800) begin
      @(negedge clk_a);
      if (tx_a !== 1'b1) viol++;
    end
    check("mid_rst_tx_idle", viol, 0);
    check("mid_rst_no_tx_done", txd_cnt_a - base_txd, 0);
    check("mid_rst_no_rx_done", rx_cnt_a - base_rx, 0);
    exp_q_a.push_back(8'h96);
    send_loop(8'h96);
    repeat (20) @(negedge clk_a);
    check("mid_rst_resend_out", {24'd0, out_a}, 32'h96);
    check("final_queue_a_empty", exp_q_a.size(), 0);
    check("done_pulse_width", width_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_txrx.md
Name: uart_txrx

Overview:
Full-duplex 8N1 UART with one transmitter and one receiver sharing a programmable baud generator. The baud generator uses 16x oversampling. Two instances in different clock domains talk over cross-connected tx/rx lines. Each instance runs at roughly the same baud rate, set by a per-instance divisor. It sits between a parallel byte producer/consumer and the serial line.

Parameters:
DATA_BITS, 8, payload bits per frame (LSB first)
OVERSAMPLE, 16, baud ticks per bit period
DIV_WIDTH, 16, width of divisor input

Ports:
clk  input  1  system clock; all logic on rising edge
areset  input  1  reset; synchronous and active-high despite the name
divisor  input  DIV_WIDTH  clocks per baud tick (bit time = 16*divisor clocks)
start  input  1  transmit request level; held high = continuous frames
in_data  input  8  byte to transmit; captured at frame start
tx  output  1  serial output, idle high
tx_done  output  1  one-cycle pulse at end of each transmitted stop bit
rx  input  1  serial input, asynchronous to clk
out_data  output  8  last correctly received byte
rx_done  output  1  one-cycle pulse when out_data is updated

Behaviour:
- Reset, one clock and synchronous reset, active-high:
  - outputs: tx=1, tx_done=0, rx_done=0, out_data=0
  - all counters 0; both FSMs in IDLE
  - reset mid-frame aborts the frame immediately, with no done pulse.
- Baud generator:
  - counter runs 0..divisor-1 and emits a one-clock tick on reaching divisor-1.
  - divisor=0 behaves as 1 (tick every clock).
  - Shared by TX and RX and free-running out of reset.
  - A divisor change takes effect at the next counter wrap.
  - Example: 100 MHz with divisor 651 gives ~9600 baud; 50 MHz with 326 gives ~9600 baud.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: tx=1. On a tick with start=1, latch in_data into the shift register and enter START.
  - START: tx=0 for 16 ticks.
  - DATA: 8 bits LSB first, 16 ticks each.
  - STOP: tx=1 for 16 ticks.
  - At the end of STOP, pulse tx_done for one clock.
  - If start=1 at that point, enter START directly (back-to-back, no idle gap) with freshly latched in_data; otherwise go to IDLE.
  - start falling mid-frame does not abort the frame.
  - in_data changes after the latch have no effect on the current frame.
- RX path:
  - rx passes through a 2-flop synchronizer, reset value 1.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE: a synchronized low enters START with the tick count cleared.
  - START: at tick 8 (mid-bit), if rx is still 0 go to DATA; else it is a false start, return to IDLE.
  - DATA: sample every 16 ticks at mid-bit and shift in LSB first, 8 bits.
  - STOP: sample at mid-bit.
    - If rx=1, load out_data and pulse rx_done for one clock.
    - If rx=0 (framing error), discard the byte: out_data is unchanged and there is no rx_done.
  - After STOP go to IDLE; RX is ready for the next start edge from the stop-bit midpoint.
  - Tolerates at least ±3% baud mismatch between sender and receiver.
- TX and RX are fully independent; simultaneous transmit and receive is supported.
- tx_done and rx_done never last more than one clock.

Test Plan:
- Reset, then divisor=4, start=0 for 500 clocks: tx stays 1; tx_done and rx_done stay 0; out_data=0.
- Divisor=4, start=1, in_data=0xA5, tx looped to rx:
  - tx=0 for 64 clocks, then bits 1,0,1,0,0,1,0,1 at 64 clocks each, then 1.
  - tx_done pulses once per frame.
  - rx_done pulses and out_data=0xA5.
- Two instances, clk 10 ns/div 651 and clk 20 ns/div 326, cross-connected:
  - A streams 10 random bytes, with in_data updated on each tx_done.
  - B's rx_done yields the identical 10 bytes in order.
- Back-to-back: start held high with 0x00 then 0xFF:
  - the next start bit begins the clock after the tx_done pulse.
  - received 0x00 then 0xFF.
- False start: rx low for 3 ticks then high: no rx_done; RX returns to IDLE and then receives 0x3C correctly.
- Framing error: drive frame 0x55 with stop=0: no rx_done and out_data keeps its previous value.
- Reset mid-frame (during DATA): tx=1 the next clock and no tx_done; a subsequent frame is sent correctly.
